divseq: RTL and testbench

Sequential radix-2 restoring divider: divides a `2*width`-bit unsigned dividend by a `width`-bit unsigned divisor and returns a `width`-bit quotient and remainder. It is the inverse companion of the FPU mantissa multiplier and sits in the FPU datapath for mantissa division. Work is started with a start/busy/done handshake and retires one quotient bit per clock.

---
 rtl/divseq_pkg.sv | 19 +
 rtl/divseq_divstep.sv | 29 ++
 rtl/divseq.sv | 131 +++++++++++++
 tb/tb_divseq.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/divseq_pkg.sv
// Shared FPU package for the sequential divider: state encoding and counter sizing.
package divseq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        ITER  = 2'd2,
        DONE  = 2'd3
    } divseq_state_t;

    localparam int default_width = 11;
    localparam int default_cnt_w = $clog2(default_width + 1);

    // Counter must hold 0..width so the divider can be resized without edits here.
    function automatic int iter_cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/divseq_divstep.sv
// One radix-2 restoring step: shift in the next dividend bit, trial-subtract the divisor.
module divstep #(
    parameter int width = 11
) (
    input  logic [width:0]   pr,
    input  logic             bit_in,
    input  logic [width-1:0] divisor,
    output logic [width:0]   pr_next,
    output logic             q_bit
);

    logic [width+1:0] trial;
    logic [width+1:0] diff;

    // NOTE: every output gets a default first, so no path leaves one unassigned and no latch appears.
    always_comb begin
        pr_next = '0;
        q_bit   = 1'b0;
        trial   = {pr, bit_in};
        diff    = trial - {2'b00, divisor};
        if (trial >= {2'b00, divisor}) begin
            pr_next = diff[width:0];
            q_bit   = 1'b1;
        end else begin
            pr_next = trial[width:0];
        end
    end

endmodule

// File: rtl/divseq.sv
// Sequential radix-2 restoring divider (2*width / width), one quotient bit per clock.
// Optional DIVSEQ_STICKY_EN registers a nonzero-remainder flag on sticky.
module divseq
    import divseq_pkg::*;
#(
    parameter int width = 11
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [2*width-1:0] dividend,
    input  logic [width-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic [width-1:0]   quotient,
    output logic [width-1:0]   remainder,
    output logic               dz,
    output logic               ovf,
    output logic               sticky
);

    localparam int cw = iter_cnt_width(width);

    divseq_state_t    state;
    logic [cw-1:0]    cnt;
    logic [width:0]   pr;
    logic [width-1:0] hi;
    logic [width-1:0] lo;
    logic [width-1:0] dvs;
    logic [width-1:0] qw;
    logic [width:0]   pr_next;
    logic             q_bit;
    logic             accept;
    logic             last;

    assign accept = start && (state == IDLE || state == DONE);
    assign last   = (state == ITER) && (cnt == cw'(width - 1));

    divstep #(.width(width)) u_step (
        .pr      (pr),
        .bit_in  (lo[width-1]),
        .divisor (dvs),
        .pr_next (pr_next),
        .q_bit   (q_bit)
    );

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            pr        <= '0;
            hi        <= '0;
            lo        <= '0;
            dvs       <= '0;
            qw        <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dz        <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        hi    <= dividend[2*width-1:width];
                        lo    <= dividend[width-1:0];
                        dvs   <= divisor;
                        dz    <= 1'b0;
                        ovf   <= 1'b0;
                        busy  <= 1'b1;
                        state <= CHECK;
                    end else begin
                        state <= IDLE;
                    end
                end
                CHECK: begin
                    if (dvs == '0 || hi >= dvs) begin
                        // Divide-by-zero wins; overflow only reported for a nonzero divisor.
                        dz        <= (dvs == '0);
                        ovf       <= (dvs != '0);
                        quotient  <= '1;
                        remainder <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        pr    <= {1'b0, hi};
                        cnt   <= '0;
                        qw    <= '0;
                        state <= ITER;
                    end
                end
                ITER: begin
                    pr  <= pr_next;
                    lo  <= {lo[width-2:0], 1'b0};
                    qw  <= {qw[width-2:0], q_bit};
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        quotient  <= {qw[width-2:0], q_bit};
                        remainder <= pr_next[width-1:0];
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DIVSEQ_STICKY_EN
    // Exception paths never set it; an accepted start clears it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sticky <= 1'b0;
        end else if (accept) begin
            sticky <= 1'b0;
        end else if (last) begin
            sticky <= |pr_next[width-1:0];
        end
    end
`else
    logic unused_accept;
    assign unused_accept = accept;
    assign sticky        = 1'b0;
`endif

endmodule

// File: tb/tb_divseq.sv
// Directed self-checking bench for divseq (width=11).
module tb_divseq;

    localparam int w = 11;
`ifdef DIVSEQ_STICKY_EN
    localparam bit sticky_en = 1'b1;
`else
    localparam bit sticky_en = 1'b0;
`endif

    logic           clock;
    logic           reset_n;
    logic           start;
    logic [2*w-1:0] dividend;
    logic [w-1:0]   divisor;
    logic           busy;
    logic           done;
    logic [w-1:0]   quotient;
    logic [w-1:0]   remainder;
    logic           dz;
    logic           ovf;
    logic           sticky;

    int checks;
    int failures;
    int n;

    divseq #(.width(w)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dz        (dz),
        .ovf       (ovf),
        .sticky    (sticky)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_q"}, 32'(quotient), 0);
        check({tag, "_r"}, 32'(remainder), 0);
        check({tag, "_dz"}, 32'(dz), 0);
        check({tag, "_ovf"}, 32'(ovf), 0);
        check({tag, "_sticky"}, 32'(sticky), 0);
    endtask

    // Wait for done; n counts negedges since the accepting edge (n=1 right after it).
    task automatic wait_done();
        n = 1;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic run_div(input string tag, input logic [2*w-1:0] dvd, input logic [w-1:0] dvs,
                           input int lat, input logic [w-1:0] q, input logic [w-1:0] r,
                           input logic edz, input logic eovf, input logic est);
        @(negedge clock);
        start    = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        @(negedge clock);
        start = 1'b0;
        check({tag, "_busy_after_start"}, 32'(busy), 1);
        wait_done();
        check({tag, "_latency"}, 32'(n), 32'(lat));
        check({tag, "_q"}, 32'(quotient), 32'(q));
        check({tag, "_r"}, 32'(remainder), 32'(r));
        check({tag, "_dz"}, 32'(dz), 32'(edz));
        check({tag, "_ovf"}, 32'(ovf), 32'(eovf));
        check({tag, "_sticky"}, 32'(sticky), 32'(est));
        check({tag, "_busy_at_done"}, 32'(busy), 0);
        @(negedge clock);
        check({tag, "_done_pulse"}, 32'(done), 0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        check_idle_zero("reset");
        @(negedge clock);
        reset_n = 1'b1;

        run_div("d1000_7", 22'd1000, 11'd7, 13, 11'd142, 11'd6, 1'b0, 1'b0, sticky_en);
        run_div("sq2047", 22'd4190209, 11'd2047, 13, 11'd2047, 11'd0, 1'b0, 1'b0, 1'b0);
        run_div("ovf", 22'd10240, 11'd5, 2, 11'h7FF, 11'd0, 1'b0, 1'b1, 1'b0);
        run_div("dz", 22'd12345, 11'd0, 2, 11'h7FF, 11'd0, 1'b1, 1'b0, 1'b0);
        run_div("small", 22'd100, 11'd10, 13, 11'd10, 11'd0, 1'b0, 1'b0, 1'b0);

        // Start during ITER is ignored; start in the done cycle is accepted.
        @(negedge clock);
        start    = 1'b1;
        dividend = 22'd1000;
        divisor  = 11'd7;
        @(negedge clock);
        start = 1'b0;
        check("ign_q_held", 32'(quotient), 10);
        n = 1;
        while (done !== 1'b1 && n < 40) begin
            if (n == 5) begin
                start    = 1'b1;
                dividend = 22'd50;
                divisor  = 11'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            n++;
        end
        check("ign_latency", 32'(n), 13);
        check("ign_q", 32'(quotient), 142);
        check("ign_r", 32'(remainder), 6);
        start    = 1'b1;
        dividend = 22'd4190209;
        divisor  = 11'd2047;
        @(negedge clock);
        start = 1'b0;
        check("b2b_busy", 32'(busy), 1);
        check("b2b_done_low", 32'(done), 0);
        check("b2b_q_held", 32'(quotient), 142);
        wait_done();
        check("b2b_latency", 32'(n), 13);
        check("b2b_q", 32'(quotient), 2047);
        check("b2b_r", 32'(remainder), 0);
        @(negedge clock);

        // Asynchronous reset in the middle of ITER.
        start    = 1'b1;
        dividend = 22'd1000;
        divisor  = 11'd7;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check_idle_zero("midreset");
        @(negedge clock);
        reset_n = 1'b1;
        run_div("after_reset", 22'd1000, 11'd7, 13, 11'd142, 11'd6, 1'b0, 1'b0, sticky_en);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
